frame_deserializer: RTL and testbench

FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

---
 rtl/frame_deserializer_pkg.sv | 12 +
 rtl/frame_deserializer_sipo_shift_reg.sv | 24 ++
 rtl/frame_deserializer.sv | 102 ++++++++++
 tb/tb_frame_deserializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_deserializer_pkg.sv
// Shared definitions for the frame deserializer: receiver state encoding and default word width.
package frame_deserializer_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/frame_deserializer_sipo_shift_reg.sv
// Serial-in/parallel-out register: shifts left with the new bit entering bit 0, holds otherwise.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             ResetB,
  input  logic             ShiftEn,
  input  logic             Sin,
  output logic [WIDTH-1:0] Pout
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      word_q <= '0;
    end else if (ShiftEn) begin
      word_q <= {word_q[WIDTH-2:0], Sin};
    end
  end

  assign Pout = word_q;

endmodule

// File: rtl/frame_deserializer.sv
// Frame receiver: start bit, WIDTH data bits MSB first, stop bit; single-slot output with
// valid/ready handshake, frame-error and overrun pulses.
module frame_deserializer
  import frame_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             ResetB,
  input  logic             BitEn,
  input  logic             Sin,
  input  logic             DoutReady,
  output logic [WIDTH-1:0] Dout,
  output logic             DoutValid,
  output logic             FrameErr,
  output logic             Overrun,
  output logic             Busy
);

  localparam int CntW = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CntW-1:0]  bitCnt_q;
  logic [WIDTH-1:0] dout_q;
  logic             doutValid_q;
  logic             frameErr_q;
  logic             overrun_q;
  logic [WIDTH-1:0] shiftWord;

  logic shiftEn_d;
  logic lastBit_d;
  logic accept_d;

  assign shiftEn_d = BitEn && (state_q == DATA);
  assign lastBit_d = (bitCnt_q == CntW'(WIDTH - 1));
  // A finished word can land if the slot is empty or is being drained on this same edge.
  assign accept_d  = !doutValid_q || DoutReady;

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .Clk    (Clk),
    .ResetB (ResetB),
    .ShiftEn(shiftEn_d),
    .Sin    (Sin),
    .Pout   (shiftWord)
  );

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      if (doutValid_q && DoutReady) begin
        doutValid_q <= 1'b0;
      end
      if (BitEn) begin
        case (state_q)
          IDLE: begin
            if (!Sin) begin
              state_q  <= DATA;
              bitCnt_q <= '0;
            end
          end
          DATA: begin
            bitCnt_q <= bitCnt_q + CntW'(1);
            if (lastBit_d) begin
              state_q <= STOP;
            end
          end
          STOP: begin
            state_q <= IDLE;
            if (Sin) begin
              if (accept_d) begin
                dout_q      <= shiftWord;
                doutValid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frameErr_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Dout      = dout_q;
  assign DoutValid = doutValid_q;
  assign FrameErr  = frameErr_q;
  assign Overrun   = overrun_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer: directed frames plus randomized traffic
// compared every cycle against a bit-position/word-value reference model.
module tb_frame_deserializer;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         ResetB = 1'b0;
  logic         BitEn = 1'b0;
  logic         Sin = 1'b1;
  logic         DoutReady = 1'b0;
  logic [W-1:0] Dout;
  logic         DoutValid;
  logic         FrameErr;
  logic         Overrun;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  // Reference model: mPos = -1 when waiting for a start bit, 0..W-1 = next data bit index,
  // W = waiting for the stop bit. The word is accumulated arithmetically.
  int mPos = -1;
  int mAcc = 0;
  int mDout = 0;
  int mValid = 0;
  int mErr = 0;
  int mOvr = 0;

  frame_deserializer #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .ResetB   (ResetB),
    .BitEn    (BitEn),
    .Sin      (Sin),
    .DoutReady(DoutReady),
    .Dout     (Dout),
    .DoutValid(DoutValid),
    .FrameErr (FrameErr),
    .Overrun  (Overrun),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge ResetB) begin
    int wasValid;
    if (!ResetB) begin
      mPos = -1; mAcc = 0; mDout = 0; mValid = 0; mErr = 0; mOvr = 0;
    end else begin
      wasValid = mValid;
      mErr = 0;
      mOvr = 0;
      if (wasValid != 0 && DoutReady) mValid = 0;
      if (BitEn) begin
        if (mPos < 0) begin
          if (!Sin) begin
            mPos = 0;
            mAcc = 0;
          end
        end else if (mPos < W) begin
          mAcc = mAcc * 2 + int'(Sin);
          mPos = mPos + 1;
        end else begin
          mPos = -1;
          if (Sin) begin
            if (wasValid == 0 || DoutReady) begin
              mDout = mAcc;
              mValid = 1;
            end else begin
              mOvr = 1;
            end
          end else begin
            mErr = 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compareModel();
    checkOutput("dout", 32'(Dout), mDout);
    checkOutput("valid", 32'(DoutValid), mValid);
    checkOutput("frameErr", 32'(FrameErr), mErr);
    checkOutput("overrun", 32'(Overrun), mOvr);
    checkOutput("busy", 32'(Busy), (mPos >= 0) ? 1 : 0);
  endtask

  // Waits for the falling edge, checks outputs against the model, then drives the next inputs.
  task automatic applyStimulus(input logic en, input logic s, input logic rdy);
    @(negedge Clk);
    compareModel();
    BitEn = en;
    Sin = s;
    DoutReady = rdy;
  endtask

  task automatic sendFrame(input int word, input logic stopBit, input int period,
                           input logic rdyData, input logic rdyStop);
    logic [W+1:0] bits;
    bits = {1'b0, W'(word), stopBit};
    for (int b = W + 1; b >= 0; b--) begin
      for (int f = 1; f < period; f++) applyStimulus(1'b0, 1'($urandom), rdyData);
      applyStimulus(1'b1, bits[b], (b == 0) ? rdyStop : rdyData);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reset_dout", 32'(Dout), 0);
    checkOutput("reset_valid", 32'(DoutValid), 0);
    checkOutput("reset_busy", 32'(Busy), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    ResetB = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);

    // Word 0xB, strobe every cycle, held until accepted.
    sendFrame(4'hB, 1'b1, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("b_dout", 32'(Dout), 32'hB);
    checkOutput("b_valid", 32'(DoutValid), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("b_held", 32'(DoutValid), 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("b_consumed", 32'(DoutValid), 0);

    // Word 0x6 with a strobe one cycle in four.
    sendFrame(4'h6, 1'b1, 4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("six_dout", 32'(Dout), 32'h6);
    checkOutput("six_valid", 32'(DoutValid), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);

    // Bad stop bit, then a good 0x3.
    sendFrame(4'hF, 1'b0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ferr_pulse", 32'(FrameErr), 1);
    checkOutput("ferr_novalid", 32'(DoutValid), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ferr_clear", 32'(FrameErr), 0);
    sendFrame(4'h3, 1'b1, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("three_dout", 32'(Dout), 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b0);

    // Overrun: 0xA pending, 0x5 arrives with no ready.
    sendFrame(4'hA, 1'b1, 1, 1'b0, 1'b0);
    sendFrame(4'h5, 1'b1, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ovr_pulse", 32'(Overrun), 1);
    checkOutput("ovr_dout", 32'(Dout), 32'hA);
    checkOutput("ovr_valid", 32'(DoutValid), 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ovr_clear", 32'(Overrun), 0);

    // 0xA still pending; ready on the stop edge of 0x5 swaps the word in.
    sendFrame(4'h5, 1'b1, 1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("swap_dout", 32'(Dout), 32'h5);
    checkOutput("swap_valid", 32'(DoutValid), 1);
    checkOutput("swap_noovr", 32'(Overrun), 0);

    // Reset after two data bits of 0xC, then a clean 0xC.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #2 ResetB = 1'b0;
    #1;
    checkOutput("rst_dout", 32'(Dout), 0);
    checkOutput("rst_valid", 32'(DoutValid), 0);
    checkOutput("rst_busy", 32'(Busy), 0);
    checkOutput("rst_ferr", 32'(FrameErr), 0);
    checkOutput("rst_ovr", 32'(Overrun), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    ResetB = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    sendFrame(4'hC, 1'b1, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("c_dout", 32'(Dout), 32'hC);
    checkOutput("c_valid", 32'(DoutValid), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'(($urandom % 3) != 0), 1'(($urandom % 3) != 0), 1'($urandom));
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
